// File: rtl/simple_axi_ram_responder.sv
// AXI4-Lite target backed by an inferred word RAM: programmable response latency,
// SLVERR on misaligned/out-of-window addresses, and transaction/error counters.
module simple_axi_ram_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  wait_cycles,
  input  logic        clear_counts,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] wr_count,
  output logic [31:0] rd_count,
  output logic [15:0] err_count,
  output logic        idle
);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;
  logic [31:0] mem [DEPTH];

  logic                 aw_held, w_held;
  logic [31:0]          aw_addr_q, w_data_q, ar_addr_q;
  logic [3:0]           w_cnt, r_cnt;
  logic [31:0]          w_off, r_off;
  logic                 w_ok, r_ok;
  logic [ADDR_BITS-1:0] w_idx, r_idx;
  logic                 aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic [1:0]           err_inc;
  logic [16:0]          err_sum;

  // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of window.
  assign w_off = aw_addr_q - BASE_ADDR;
  assign r_off = ar_addr_q - BASE_ADDR;
  assign w_ok  = (aw_addr_q[1:0] == 2'b00) && ((w_off >> (ADDR_BITS + 2)) == 32'd0);
  assign r_ok  = (ar_addr_q[1:0] == 2'b00) && ((r_off >> (ADDR_BITS + 2)) == 32'd0);
  assign w_idx = w_off[ADDR_BITS+1:2];
  assign r_idx = r_off[ADDR_BITS+1:2];

  assign awready = reset_n && (w_state == W_IDLE) && !aw_held;
  assign wready  = reset_n && (w_state == W_IDLE) && !w_held;
  assign arready = reset_n && (r_state == R_IDLE);
  assign idle    = (w_state == W_IDLE) && (r_state == R_IDLE) && !aw_held && !w_held;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign b_hs  = bvalid && bready;
  assign r_hs  = rvalid && rready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= 32'h0;
      w_data_q  <= 32'h0;
      w_cnt     <= 4'd0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= awaddr;
            w_cnt     <= wait_cycles;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= wdata;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) w_state <= W_WAIT;
        end
        W_WAIT: begin
          if (w_cnt == 4'd0) begin
            bvalid  <= 1'b1;
            bresp   <= w_ok ? OKAY : SLVERR;
            w_state <= W_RESP;
          end else begin
            w_cnt <= w_cnt - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM contents survive reset; a reset before commit leaves w_state idle, so nothing lands.
  always_ff @(posedge clk) begin
    if ((w_state == W_WAIT) && (w_cnt == 4'd0) && w_ok) mem[w_idx] <= w_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= R_IDLE;
      ar_addr_q <= 32'h0;
      r_cnt     <= 4'd0;
      rvalid    <= 1'b0;
      rresp     <= OKAY;
      rdata     <= 32'h0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            ar_addr_q <= araddr;
            r_cnt     <= wait_cycles;
            r_state   <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) begin
            rvalid  <= 1'b1;
            rresp   <= r_ok ? OKAY : SLVERR;
            rdata   <= r_ok ? mem[r_idx] : 32'h0;
            r_state <= R_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Both channels can finish an SLVERR on the same edge, hence a 2-bit increment.
  always_comb begin
    err_inc = {1'b0, b_hs && (bresp == SLVERR)} + {1'b0, r_hs && (rresp == SLVERR)};
    err_sum = {1'b0, err_count} + {15'b0, err_inc};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count  <= 32'h0;
      rd_count  <= 32'h0;
      err_count <= 16'h0;
    end else if (clear_counts) begin
      wr_count  <= 32'h0;
      rd_count  <= 32'h0;
      err_count <= 16'h0;
    end else begin
      if (b_hs) wr_count <= wr_count + 32'd1;
      if (r_hs) rd_count <= rd_count + 32'd1;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule
